// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: default widths and the
// three-phase iteration encoding the controller steps through.
package div_pkg;

  localparam int DIV_N     = 8;
  localparam int DIV_CNT_W = $clog2(DIV_N) + 1;

  typedef enum logic [1:0] {
    PH_SHIFT = 2'd0,
    PH_SUB   = 2'd1,
    PH_COUNT = 2'd2
  } div_phase_e;

  localparam int PHASES_PER_ITER = 3;

endpackage

// File: rtl/div_counter.sv
// Iteration counter for the divider: clears, increments, and saturates at N
// so extra increments from the controller never wrap back to zero.
module div_counter
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(N);

  assign done = (count == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/div_datapath.sv
// Restoring-division datapath: R/Q/M registers and iteration counter,
// sequenced entirely by an external controller through the strobe inputs.
module div_datapath
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         Rreset,
  input  logic         Rshift,
  input  logic         Rload,
  input  logic         Qload,
  input  logic         Qshift,
  input  logic         Mload,
  input  logic         Cup,
  input  logic         Creset,
  output logic         sub_neg,
  output logic         cnt_done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  logic [N:0]       r_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     m_reg;
  logic [N+1:0]     diff;
  logic [CNT_W-1:0] count;
  logic             dbz_reg;

  // One extra bit beyond R so the borrow lands in the MSB and doubles as R < M.
  assign diff    = {1'b0, r_reg} - {2'b00, m_reg};
  assign sub_neg = diff[N+1];

  assign quotient    = q_reg;
  assign remainder   = r_reg[N-1:0];
  assign div_by_zero = dbz_reg;

  // A negative trial difference simply skips the load, so no restore cycle is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg <= '0;
    end else if (Rreset) begin
      r_reg <= '0;
    end else if (Rload) begin
      if (!sub_neg) r_reg <= diff[N:0];
    end else if (Rshift) begin
      r_reg <= {r_reg[N-1:0], q_reg[N-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (Qload) begin
      q_reg <= dividend;
    end else if (Qshift) begin
      q_reg <= {q_reg[N-2:0], ~sub_neg};
    end
  end

  // The zero-divisor flag tracks the operand as it is captured, not M afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      dbz_reg <= 1'b0;
    end else if (Mload) begin
      m_reg   <= divisor;
      dbz_reg <= (divisor == '0);
    end
  end

  div_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (Creset),
    .inc   (Cup),
    .count (count),
    .done  (cnt_done)
  );

endmodule

// File: tb/tb_div_datapath.sv
// Directed bench for div_datapath: drives controller strobes by hand and
// checks quotient/remainder/flags against hand-computed results.
module tb_div_datapath;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         Rreset, Rshift, Rload, Qload, Qshift, Mload, Cup, Creset;
  logic         sub_neg, cnt_done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int checkCount = 0;
  int passCount  = 0;

  div_datapath #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .dividend    (dividend),
    .divisor     (divisor),
    .Rreset      (Rreset),
    .Rshift      (Rshift),
    .Rload       (Rload),
    .Qload       (Qload),
    .Qshift      (Qshift),
    .Mload       (Mload),
    .Cup         (Cup),
    .Creset      (Creset),
    .sub_neg     (sub_neg),
    .cnt_done    (cnt_done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Holds the given strobes for one rising edge, then releases them 1ns after.
  task automatic applyStimulus(input logic rr, input logic rs, input logic rl,
                               input logic ql, input logic qs, input logic ml,
                               input logic cu, input logic cr);
    Rreset = rr; Rshift = rs; Rload = rl; Qload = ql;
    Qshift = qs; Mload = ml; Cup = cu; Creset = cr;
    @(posedge clk);
    #1;
    Rreset = 0; Rshift = 0; Rload = 0; Qload = 0;
    Qshift = 0; Mload = 0; Cup = 0; Creset = 0;
  endtask

  task automatic loadOperands(input logic [N-1:0] dd, input logic [N-1:0] dv);
    dividend = dd;
    divisor  = dv;
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 1);
  endtask

  task automatic runIteration(input bit checkNeg, input string tag);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    if (checkNeg) checkOutput(tag, 16'(sub_neg), 16'd1);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic runIterations(input int count);
    for (int i = 0; i < count; i++) runIteration(0, "");
  endtask

  initial begin
    rst = 1'b1;
    dividend = '0; divisor = '0;
    Rreset = 0; Rshift = 0; Rload = 0; Qload = 0;
    Qshift = 0; Mload = 0; Cup = 0; Creset = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_quotient", 16'(quotient), 16'd0);
    checkOutput("reset_remainder", 16'(remainder), 16'd0);
    checkOutput("reset_cnt_done", 16'(cnt_done), 16'd0);
    checkOutput("reset_sub_neg", 16'(sub_neg), 16'd0);
    checkOutput("reset_dbz", 16'(div_by_zero), 16'd0);

    // 100 / 7 = 14 r 2
    loadOperands(8'd100, 8'd7);
    checkOutput("100_7_loaded_q", 16'(quotient), 16'd100);
    runIterations(7);
    checkOutput("100_7_not_done", 16'(cnt_done), 16'd0);
    runIterations(1);
    checkOutput("100_7_quotient", 16'(quotient), 16'd14);
    checkOutput("100_7_remainder", 16'(remainder), 16'd2);
    checkOutput("100_7_cnt_done", 16'(cnt_done), 16'd1);
    checkOutput("100_7_dbz", 16'(div_by_zero), 16'd0);

    // With no strobes everything holds.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_quotient", 16'(quotient), 16'd14);
    checkOutput("hold_remainder", 16'(remainder), 16'd2);

    // 255 / 1 = 255 r 0
    loadOperands(8'd255, 8'd1);
    runIterations(8);
    checkOutput("255_1_quotient", 16'(quotient), 16'd255);
    checkOutput("255_1_remainder", 16'(remainder), 16'd0);

    // 5 / 9 = 0 r 5, every trial subtraction negative
    loadOperands(8'd5, 8'd9);
    for (int i = 0; i < 8; i++) runIteration(1, "5_9_sub_neg");
    checkOutput("5_9_quotient", 16'(quotient), 16'd0);
    checkOutput("5_9_remainder", 16'(remainder), 16'd5);

    // 37 / 0: no special case, all-ones quotient
    loadOperands(8'd37, 8'd0);
    checkOutput("37_0_dbz_after_load", 16'(div_by_zero), 16'd1);
    runIterations(8);
    checkOutput("37_0_quotient", 16'(quotient), 16'd255);
    checkOutput("37_0_remainder", 16'(remainder), 16'd37);
    checkOutput("37_0_dbz", 16'(div_by_zero), 16'd1);

    // Abort 100 / 7 after 3 iterations with an asynchronous reset pulse.
    loadOperands(8'd100, 8'd7);
    runIterations(3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_quotient", 16'(quotient), 16'd0);
    checkOutput("abort_remainder", 16'(remainder), 16'd0);
    checkOutput("abort_cnt_done", 16'(cnt_done), 16'd0);
    checkOutput("abort_dbz", 16'(div_by_zero), 16'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 200 / 13 = 15 r 5
    loadOperands(8'd200, 8'd13);
    runIterations(8);
    checkOutput("200_13_quotient", 16'(quotient), 16'd15);
    checkOutput("200_13_remainder", 16'(remainder), 16'd5);
    checkOutput("200_13_cnt_done", 16'(cnt_done), 16'd1);

    // Priority: Rreset beats Rload/Rshift, Creset beats Cup.
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 1);
    checkOutput("prio_remainder", 16'(remainder), 16'd0);
    checkOutput("prio_cnt_done", 16'(cnt_done), 16'd0);
    checkOutput("prio_quotient", 16'(quotient), 16'd15);

    // Counter reaches N after 8 increments and saturates there.
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("cup7_cnt_done", 16'(cnt_done), 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("cup8_cnt_done", 16'(cnt_done), 16'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("cup10_saturated", 16'(cnt_done), 16'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
